frame_buffer_arbiter: RTL and testbench

- Shares one single-port 320x240 8-bit frame buffer RAM between three clients: a display reader, a host writer and a host reader.
- Display reader: real-time, top priority. Host writer: buffered through an internal write FIFO. Host reader: lowest priority, with an anti-starvation promotion.
- Drives the RAM's addr/data_in/write/ENABLE pins and routes the RAM's out_data back to the client that issued the read.

---
 rtl/frame_buffer_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_frame_buffer_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter
//   Shares one single-port frame buffer RAM between a real-time display
//   reader, a FIFO-buffered host writer and a low-priority host reader.
//   Arbitration order per cycle: promoted client (full write FIFO, then
//   starved host read), display, write FIFO head, host read.
//   Reads have a fixed 2-cycle latency from the grant edge to rvalid.
//
// Ports
//   CLOCK_50, RESET            clock, async active-high reset
//   disp_req/addr/gnt          display read request (gnt is combinational)
//   disp_rvalid/rdata          display read return
//   wr_valid/addr/data/ready   host write push into the write FIFO
//   hr_req/addr/gnt            host read request (gnt is combinational)
//   hr_rvalid/rdata            host read return
//   mem_addr/data_in/write/enable  registered RAM controls
//   mem_rdata                  RAM out_data
//   wfifo_level                write FIFO occupancy
//
// Optional: define FBARB_STATS_EN to add stat_clr and the saturating
//   per-client access counters stat_disp / stat_wr / stat_hr.
module frame_buffer_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 20,
  parameter int DEPTH        = 76800,
  parameter int WFIFO_DEPTH  = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET,
  input  logic                          disp_req,
  input  logic [ADDR_WIDTH-1:0]         disp_addr,
  output logic                          disp_gnt,
  output logic                          disp_rvalid,
  output logic [DATA_WIDTH-1:0]         disp_rdata,
  input  logic                          wr_valid,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_ready,
  input  logic                          hr_req,
  input  logic [ADDR_WIDTH-1:0]         hr_addr,
  output logic                          hr_gnt,
  output logic                          hr_rvalid,
  output logic [DATA_WIDTH-1:0]         hr_rdata,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_data_in,
  output logic                          mem_write,
  output logic                          mem_enable,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic [$clog2(WFIFO_DEPTH):0]  wfifo_level
`ifdef FBARB_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [15:0]                   stat_disp,
  output logic [15:0]                   stat_wr,
  output logic [15:0]                   stat_hr
`endif
);

  localparam int LW = $clog2(WFIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [7:0]            SLIM    = 8'(STARVE_LIMIT);
  localparam logic [LW:0]           FULL_L  = (LW+1)'(WFIFO_DEPTH);

  typedef enum logic [1:0] {SEL_NONE, SEL_DISP, SEL_WR, SEL_HR} sel_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HR} tag_e;

  // write FIFO
  logic [ADDR_WIDTH-1:0] fa_q [WFIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fd_q [WFIFO_DEPTH];
  logic [LW-1:0]         wptr_q, rptr_q;
  logic [LW:0]           lvl_q;
  logic                  full, empty, push, pop;

  // arbitration / issue state
  sel_e                  sel;
  logic [7:0]            starve_q, starve_d;
  logic                  wr_prom, hr_prom;
  logic                  disp_inr, hr_inr, head_inr;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_q;
  logic                  mem_write_q, mem_enable_q;

  // two-stage return tag pipeline; oor marks an out-of-range read whose
  // data is forced to 0 regardless of what the RAM drives
  tag_e                  tag_q [2];
  logic [1:0]            oor_q;
  logic                  disp_rvalid_q, hr_rvalid_q;
  logic [DATA_WIDTH-1:0] disp_rdata_q, hr_rdata_q;

  assign full      = (lvl_q == FULL_L);
  assign empty     = (lvl_q == '0);
  assign wr_ready  = !full;
  assign push      = wr_valid && !full;
  assign head_addr = fa_q[rptr_q];
  assign head_data = fd_q[rptr_q];

  assign disp_inr  = disp_addr < DEPTH_A;
  assign hr_inr    = hr_addr   < DEPTH_A;
  assign head_inr  = head_addr < DEPTH_A;

  assign wr_prom   = full;
  assign hr_prom   = hr_req && (starve_q == SLIM);

  always_comb begin
    sel = SEL_NONE;
    if      (wr_prom)  sel = SEL_WR;
    else if (hr_prom)  sel = SEL_HR;
    else if (disp_req) sel = SEL_DISP;
    else if (!empty)   sel = SEL_WR;
    else if (hr_req)   sel = SEL_HR;
  end

  assign disp_gnt = (sel == SEL_DISP);
  assign hr_gnt   = (sel == SEL_HR);
  assign pop      = (sel == SEL_WR);

  always_comb begin
    starve_d = starve_q;
    if (!hr_req || hr_gnt)  starve_d = '0;
    else if (starve_q != SLIM) starve_d = starve_q + 8'd1;
  end

  // FIFO storage needs no reset; occupancy alone defines validity
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      fa_q[wptr_q] <= wr_addr;
      fd_q[wptr_q] <= wr_data;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      lvl_q    <= '0;
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      lvl_q <= lvl_q + 1'b1;
      else if (pop && !push) lvl_q <= lvl_q - 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      mem_write_q   <= 1'b0;
      mem_enable_q  <= 1'b0;
      tag_q[0]      <= TAG_NONE;
      tag_q[1]      <= TAG_NONE;
      oor_q         <= '0;
      disp_rvalid_q <= 1'b0;
      hr_rvalid_q   <= 1'b0;
      disp_rdata_q  <= '0;
      hr_rdata_q    <= '0;
    end else begin
      // idle default: strobes drop, address/data hold
      mem_write_q  <= 1'b0;
      mem_enable_q <= 1'b0;
      tag_q[0]     <= TAG_NONE;
      oor_q[0]     <= 1'b0;
      case (sel)
        SEL_DISP: begin
          mem_addr_q   <= disp_addr;
          mem_enable_q <= disp_inr;
          tag_q[0]     <= TAG_DISP;
          oor_q[0]     <= !disp_inr;
        end
        SEL_HR: begin
          mem_addr_q   <= hr_addr;
          mem_enable_q <= hr_inr;
          tag_q[0]     <= TAG_HR;
          oor_q[0]     <= !hr_inr;
        end
        SEL_WR: begin
          // out-of-range head is popped and dropped without a RAM cycle
          if (head_inr) begin
            mem_addr_q   <= head_addr;
            mem_data_q   <= head_data;
            mem_write_q  <= 1'b1;
            mem_enable_q <= 1'b1;
          end
        end
        default: ;
      endcase
      tag_q[1]      <= tag_q[0];
      oor_q[1]      <= oor_q[0];
      disp_rvalid_q <= (tag_q[1] == TAG_DISP);
      hr_rvalid_q   <= (tag_q[1] == TAG_HR);
      if (tag_q[1] == TAG_DISP) disp_rdata_q <= oor_q[1] ? '0 : mem_rdata;
      if (tag_q[1] == TAG_HR)   hr_rdata_q   <= oor_q[1] ? '0 : mem_rdata;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_q;
  assign mem_write   = mem_write_q;
  assign mem_enable  = mem_enable_q;
  assign disp_rvalid = disp_rvalid_q;
  assign hr_rvalid   = hr_rvalid_q;
  assign disp_rdata  = disp_rdata_q;
  assign hr_rdata    = hr_rdata_q;
  assign wfifo_level = lvl_q;

`ifdef FBARB_STATS_EN
  logic [15:0] st_disp_q, st_wr_q, st_hr_q;

  // counts issued grants (a dropped out-of-range write still counts as issued)
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      st_disp_q <= '0;
      st_wr_q   <= '0;
      st_hr_q   <= '0;
    end else if (stat_clr) begin
      st_disp_q <= '0;
      st_wr_q   <= '0;
      st_hr_q   <= '0;
    end else begin
      if (sel == SEL_DISP && st_disp_q != 16'hFFFF) st_disp_q <= st_disp_q + 16'd1;
      if (sel == SEL_WR   && st_wr_q   != 16'hFFFF) st_wr_q   <= st_wr_q   + 16'd1;
      if (sel == SEL_HR   && st_hr_q   != 16'hFFFF) st_hr_q   <= st_hr_q   + 16'd1;
    end
  end

  assign stat_disp = st_disp_q;
  assign stat_wr   = st_wr_q;
  assign stat_hr   = st_hr_q;
`endif

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter with a behavioural single-port RAM
// (returns 255 during writes, 0 when not enabled).
module tb_frame_buffer_arbiter;
  localparam int DW = 8;
  localparam int AW = 20;
  localparam int DEPTH = 76800;

  logic          CLOCK_50 = 1'b0;
  logic          RESET = 1'b1;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_gnt, disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          hr_req = 1'b0;
  logic [AW-1:0] hr_addr = '0;
  logic          hr_gnt, hr_rvalid;
  logic [DW-1:0] hr_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic          mem_write, mem_enable;
  logic [DW-1:0] mem_rdata;
  logic [3:0]    wfifo_level;
`ifdef FBARB_STATS_EN
  logic          stat_clr = 1'b0;
  logic [15:0]   stat_disp, stat_wr, stat_hr;
`endif

  int checks = 0;
  int errors = 0;
  int bad255 = 0;

  frame_buffer_arbiter dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .hr_req(hr_req), .hr_addr(hr_addr), .hr_gnt(hr_gnt),
    .hr_rvalid(hr_rvalid), .hr_rdata(hr_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write(mem_write),
    .mem_enable(mem_enable), .mem_rdata(mem_rdata), .wfifo_level(wfifo_level)
`ifdef FBARB_STATS_EN
    , .stat_clr(stat_clr), .stat_disp(stat_disp), .stat_wr(stat_wr), .stat_hr(stat_hr)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // RAM model; a few locations are preloaded while RESET is high
  logic [DW-1:0] ram [DEPTH];
  always @(posedge CLOCK_50) begin
    if (RESET) begin
      ram[5] <= 8'h3C;
      ram[7] <= 8'h77;
      ram[9] <= 8'h01;
      mem_rdata <= '0;
    end else if (mem_enable && mem_addr < AW'(DEPTH)) begin
      if (mem_write) begin
        ram[mem_addr] <= mem_data_in;
        mem_rdata <= 8'hFF;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end else begin
      mem_rdata <= '0;
    end
  end

  always @(negedge CLOCK_50)
    if ((disp_rvalid && disp_rdata == 8'hFF) || (hr_rvalid && hr_rdata == 8'hFF))
      bad255++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    int n;
    int seen;

    // ---- reset state
    repeat (2) tick;
    chk("rst_men",   32'(mem_enable), 0);
    chk("rst_mwr",   32'(mem_write), 0);
    chk("rst_maddr", 32'(mem_addr), 0);
    chk("rst_drv",   32'(disp_rvalid), 0);
    chk("rst_hrv",   32'(hr_rvalid), 0);
    chk("rst_lvl",   32'(wfifo_level), 0);
    chk("rst_wrdy",  32'(wr_ready), 1);
    RESET = 1'b0;
    tick;

    // ---- display read, 2-cycle latency
    disp_req = 1'b1; disp_addr = 20'd5;
    #1;
    chk("d_gnt", 32'(disp_gnt), 1);
    tick;                                   // accept edge t
    disp_req = 1'b0;
    chk("d_men",   32'(mem_enable), 1);
    chk("d_maddr", 32'(mem_addr), 5);
    chk("d_rv_t0", 32'(disp_rvalid), 0);
    tick;                                   // t+1
    chk("d_rv_t1", 32'(disp_rvalid), 0);
    tick;                                   // t+2
    chk("d_rv_t2", 32'(disp_rvalid), 1);
    chk("d_rdata", 32'(disp_rdata), 32'h3C);
    tick;
    chk("d_rv_t3", 32'(disp_rvalid), 0);
    chk("d_hold",  32'(disp_rdata), 32'h3C);

    // ---- fill FIFO under display load; full FIFO preempts display
    disp_req = 1'b1; disp_addr = 20'd0;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(100 + i); wr_data = DW'(8'h10 + i);
      tick;
    end
    wr_valid = 1'b0;
    #1;
    chk("f_lvl8",  32'(wfifo_level), 8);
    chk("f_wrdy0", 32'(wr_ready), 0);
    chk("f_dgnt0", 32'(disp_gnt), 0);
    tick;
    chk("f_mwr",   32'(mem_write), 1);
    chk("f_maddr", 32'(mem_addr), 100);
    chk("f_mdat",  32'(mem_data_in), 32'h10);
    chk("f_lvl7",  32'(wfifo_level), 7);
    chk("f_wrdy1", 32'(wr_ready), 1);
    chk("f_dgnt1", 32'(disp_gnt), 1);
    disp_req = 1'b0;
    n = 0;
    while (wfifo_level != 0 && n < 40) begin tick; n++; end
    chk("f_drain", 32'(wfifo_level), 0);
    tick;
    chk("f_ram107", 32'(ram[107]), 32'h17);

    // ---- host read starvation promotion
    disp_req = 1'b1; disp_addr = 20'd0;
    hr_req = 1'b1; hr_addr = 20'd7;
    #1;
    n = 0;
    while (!hr_gnt && n < 40) begin tick; n++; end
    chk("s_wait", 32'(n), 16);
    chk("s_dg0",  32'(disp_gnt), 0);
    tick;                                   // accept
    hr_req = 1'b0;
    tick;
    chk("s_rv1", 32'(hr_rvalid), 0);
    tick;
    chk("s_rv2", 32'(hr_rvalid), 1);
    chk("s_rd",  32'(hr_rdata), 32'h77);
    hr_req = 1'b1;
    #1;
    chk("s_cntclr", 32'(hr_gnt), 0);        // counter restarted from 0
    hr_req = 1'b0; disp_req = 1'b0;
    tick;

    // ---- out-of-range read and write
    hr_req = 1'b1; hr_addr = 20'd80000;
    #1;
    chk("o_gnt", 32'(hr_gnt), 1);
    tick;
    hr_req = 1'b0;
    chk("o_men", 32'(mem_enable), 0);
    tick; tick;
    chk("o_rv", 32'(hr_rvalid), 1);
    chk("o_rd", 32'(hr_rdata), 0);
    wr_valid = 1'b1; wr_addr = 20'd80000; wr_data = 8'h55;
    tick;
    wr_valid = 1'b0;
    chk("o_lvl1", 32'(wfifo_level), 1);
    tick;
    chk("o_mwr",  32'(mem_write), 0);
    chk("o_men2", 32'(mem_enable), 0);
    chk("o_lvl0", 32'(wfifo_level), 0);

    // ---- write then read same address
    wr_valid = 1'b1; wr_addr = 20'd9; wr_data = 8'hAA;
    tick;                                   // push
    wr_valid = 1'b0;
    tick;                                   // write issued
    chk("w_mwr", 32'(mem_write), 1);
    chk("w_ma",  32'(mem_addr), 9);
    disp_req = 1'b1; disp_addr = 20'd9;
    tick;                                   // read issued
    disp_req = 1'b0;
    tick; tick;
    chk("w_rv", 32'(disp_rvalid), 1);
    chk("w_rd", 32'(disp_rdata), 32'hAA);
    tick;

    // ---- reset with a read in flight and a queued write
    disp_req = 1'b1; disp_addr = 20'd5;
    wr_valid = 1'b1; wr_addr = 20'd50; wr_data = 8'h01;
    tick;                                   // read accepted, write pushed
    wr_valid = 1'b0;
    chk("r_lvl1", 32'(wfifo_level), 1);
    tick;
    disp_req = 1'b0;
    RESET = 1'b1;
    #1;
    chk("r_lvl0",  32'(wfifo_level), 0);
    chk("r_men",   32'(mem_enable), 0);
    chk("r_maddr", 32'(mem_addr), 0);
    chk("r_drv",   32'(disp_rvalid), 0);
    chk("r_drd",   32'(disp_rdata), 0);
    chk("r_hrd",   32'(hr_rdata), 0);
    tick;
    RESET = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (disp_rvalid) seen++;
    end
    chk("r_norv", 32'(seen), 0);
    chk("no255",  32'(bad255), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
